// File: rtl/mem_bus_bridge.sv
`timescale 1ns/1ps
// Bridges decoupled CPU memory requests onto a req/ack wait-state bus, one
// transaction at a time, and returns one in-order response per request.
module mem_bus_bridge #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255,
    parameter int BE_W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_we,
    input  logic [BE_W-1:0]   req_be,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [BE_W-1:0]   bus_be,
    output logic [31:0]       bus_wdata,
    input  logic              bus_ack,
    input  logic              bus_err,
    input  logic [31:0]       bus_rdata
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [BE_W-1:0]   be_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic              err_q;
    logic              timeout_hit;

    // An ack arriving on the last allowed cycle still counts as a normal completion.
    assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST) && !bus_ack;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid)              state_nxt = BUS;
            BUS:     if (bus_ack || timeout_hit) state_nxt = RESP;
            RESP:    if (resp_ready)             state_nxt = IDLE;
            default:                             state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state == IDLE && req_valid) begin
                addr_q  <= {req_addr[ADDR_W-1:2], 2'b00};
                we_q    <= req_we;
                be_q    <= req_we ? req_be : '1;
                wdata_q <= req_wdata;
                cnt     <= '0;
            end
            if (state == BUS) begin
                if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
                if (bus_ack) begin
                    rdata_q <= we_q ? 32'd0 : bus_rdata;
                    err_q   <= bus_err;
                end else if (timeout_hit) begin
                    rdata_q <= 32'd0;
                    err_q   <= 1'b1;
                end
            end
        end
    end

    // Ready is masked by reset so the upstream never sees a handshake while held in reset.
    assign req_ready  = rst && (state == IDLE);
    assign resp_valid = (state == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign bus_req    = (state == BUS);
    assign bus_we     = we_q;
    assign bus_addr   = addr_q;
    assign bus_be     = be_q;
    assign bus_wdata  = wdata_q;

endmodule

// File: tb/tb_mem_bus_bridge.sv
`timescale 1ns/1ps
// Self-checking bench for mem_bus_bridge: directed vector table, reset and stray-ack
// sequences, and random transactions checked against a transaction-level model.
module tb_mem_bus_bridge;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic        bus_req, bus_we, bus_ack, bus_err;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          waits;
        logic        ackErr;
        logic [31:0] rdata;
        int          readyDelay;
        logic [31:0] expAddr;
        logic [3:0]  expBe;
        logic [31:0] expRdata;
        logic        expErr;
        int          expCycles;
    } vec_t;

    mem_bus_bridge #(.ADDR_W(32), .TIMEOUT(TO), .BE_W(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_we(req_we), .req_be(req_be), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_err(bus_err), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Transaction-level expectation: aligned address, read enables forced on,
    // completion after waits+1 bus cycles unless that exceeds the timeout budget.
    function automatic vec_t modelTxn(input vec_t v);
        vec_t r = v;
        r.expAddr = {v.addr[31:2], 2'b00};
        r.expBe   = v.we ? v.be : 4'hF;
        if (v.waits + 1 <= TO) begin
            r.expCycles = v.waits + 1;
            r.expRdata  = v.we ? 32'd0 : v.rdata;
            r.expErr    = v.ackErr;
        end else begin
            r.expCycles = TO;
            r.expRdata  = 32'd0;
            r.expErr    = 1'b1;
        end
        return r;
    endfunction

    task automatic applyStimulus(input vec_t v, input string tag);
        int busCycles = 0;
        checkOutput({tag, ".req_ready_idle"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_addr  = v.addr;
        req_we    = v.we;
        req_be    = v.be;
        req_wdata = v.wdata;
        tick();
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        while (bus_req === 1'b1 && busCycles < 50) begin
            busCycles++;
            checkOutput({tag, ".bus_addr"},  bus_addr, v.expAddr);
            checkOutput({tag, ".bus_be"},    {28'd0, bus_be}, {28'd0, v.expBe});
            checkOutput({tag, ".bus_we"},    {31'd0, bus_we}, {31'd0, v.we});
            checkOutput({tag, ".bus_wdata"}, bus_wdata, v.wdata);
            checkOutput({tag, ".req_ready_bus"}, {31'd0, req_ready}, 32'd0);
            if (busCycles == v.waits + 1) begin
                bus_ack   = 1'b1;
                bus_err   = v.ackErr;
                bus_rdata = v.rdata;
            end
            tick();
            bus_ack   = 1'b0;
            bus_err   = 1'b0;
            bus_rdata = $urandom;
        end
        checkOutput({tag, ".bus_cycles"}, busCycles, v.expCycles);
        for (int i = 0; i < v.readyDelay; i++) begin
            checkOutput({tag, ".resp_valid_stall"}, {31'd0, resp_valid}, 32'd1);
            checkOutput({tag, ".resp_rdata_stall"}, resp_rdata, v.expRdata);
            checkOutput({tag, ".req_ready_stall"},  {31'd0, req_ready}, 32'd0);
            checkOutput({tag, ".bus_req_stall"},    {31'd0, bus_req}, 32'd0);
            tick();
        end
        checkOutput({tag, ".resp_valid"}, {31'd0, resp_valid}, 32'd1);
        checkOutput({tag, ".resp_rdata"}, resp_rdata, v.expRdata);
        checkOutput({tag, ".resp_err"},   {31'd0, resp_err}, {31'd0, v.expErr});
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        checkOutput({tag, ".resp_done"},  {31'd0, resp_valid}, 32'd0);
        checkOutput({tag, ".req_ready_after"}, {31'd0, req_ready}, 32'd1);
    endtask

    vec_t table_v[8];
    vec_t rv;

    initial begin
        //             addr          we  be     wdata         waits ackErr rdata        rdly expAddr       expBe  expRdata      expErr cyc
        table_v[0] = '{32'h8000_0004, 1'b0, 4'h0, 32'h0,       0,   1'b0, 32'hDEADBEEF, 0, 32'h8000_0004, 4'hF, 32'hDEADBEEF, 1'b0, 1};
        table_v[1] = '{32'h0000_0010, 1'b1, 4'h3, 32'h1234,    3,   1'b0, 32'hFFFFFFFF, 5, 32'h0000_0010, 4'h3, 32'h0,        1'b0, 4};
        table_v[2] = '{32'h0000_0020, 1'b0, 4'hF, 32'h0,       255, 1'b0, 32'h5555AAAA, 1, 32'h0000_0020, 4'hF, 32'h0,        1'b1, 8};
        table_v[3] = '{32'h0000_0044, 1'b0, 4'hF, 32'h0,       0,   1'b0, 32'h11111111, 0, 32'h0000_0044, 4'hF, 32'h11111111, 1'b0, 1};
        table_v[4] = '{32'h0000_0048, 1'b0, 4'hF, 32'h0,       1,   1'b1, 32'h22222222, 0, 32'h0000_0048, 4'hF, 32'h22222222, 1'b1, 2};
        table_v[5] = '{32'h0000_0103, 1'b1, 4'hA, 32'hA5A5,    2,   1'b0, 32'h0,        2, 32'h0000_0100, 4'hA, 32'h0,        1'b0, 3};
        table_v[6] = '{32'h0000_0200, 1'b0, 4'hF, 32'h0,       7,   1'b0, 32'hCAFEF00D, 0, 32'h0000_0200, 4'hF, 32'hCAFEF00D, 1'b0, 8};
        table_v[7] = '{32'h0000_0300, 1'b1, 4'hC, 32'h77,      0,   1'b1, 32'h99999999, 0, 32'h0000_0300, 4'hC, 32'h0,        1'b1, 1};

        rst = 1'b0;
        req_valid = 1'b0; req_addr = '0; req_we = 1'b0; req_be = '0; req_wdata = '0;
        resp_ready = 1'b0; bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = '0;
        tick(); tick();
        checkOutput("reset.req_ready",  {31'd0, req_ready},  32'd0);
        checkOutput("reset.resp_valid", {31'd0, resp_valid}, 32'd0);
        checkOutput("reset.bus_req",    {31'd0, bus_req},    32'd0);
        checkOutput("reset.bus_addr",   bus_addr,            32'd0);
        checkOutput("reset.bus_wdata",  bus_wdata,           32'd0);
        checkOutput("reset.bus_be",     {28'd0, bus_be},     32'd0);
        rst = 1'b1;
        tick();
        checkOutput("post_reset.req_ready", {31'd0, req_ready}, 32'd1);

        for (int i = 0; i < 8; i++) applyStimulus(table_v[i], $sformatf("vec%0d", i));

        // A stray ack while idle must not start or complete anything.
        bus_ack = 1'b1; bus_rdata = 32'h12345678;
        tick();
        bus_ack = 1'b0;
        tick();
        checkOutput("stray_ack.bus_req",    {31'd0, bus_req},    32'd0);
        checkOutput("stray_ack.resp_valid", {31'd0, resp_valid}, 32'd0);
        checkOutput("stray_ack.req_ready",  {31'd0, req_ready},  32'd1);

        // Reset while the bus is waiting abandons the transaction immediately.
        req_valid = 1'b1; req_addr = 32'h40; req_we = 1'b0; req_be = 4'hF;
        tick();
        req_valid = 1'b0;
        tick();
        checkOutput("midreset.bus_req_before", {31'd0, bus_req}, 32'd1);
        rst = 1'b0;
        #1;
        checkOutput("midreset.bus_req",    {31'd0, bus_req},    32'd0);
        checkOutput("midreset.resp_valid", {31'd0, resp_valid}, 32'd0);
        checkOutput("midreset.req_ready",  {31'd0, req_ready},  32'd0);
        tick();
        rst = 1'b1;
        tick();
        checkOutput("midreset.resp_after", {31'd0, resp_valid}, 32'd0);
        applyStimulus(table_v[3], "after_reset");

        for (int n = 0; n < 24; n++) begin
            rv.addr       = $urandom;
            rv.we         = 1'($urandom_range(0, 1));
            rv.be         = 4'($urandom_range(0, 15));
            rv.wdata      = $urandom;
            rv.waits      = $urandom_range(0, 10);
            rv.ackErr     = 1'($urandom_range(0, 1));
            rv.rdata      = $urandom;
            rv.readyDelay = $urandom_range(0, 3);
            rv = modelTxn(rv);
            applyStimulus(rv, $sformatf("rand%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
